// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial shift-register link.
package serial_link_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter width for a modulus x, never narrower than one bit.
    function automatic int cnt_width(input int x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/serial_word_tx_bit_tick_gen.sv
// Bit-period divider: tick is registered and high in the last cycle of each bit period.
module bit_tick_gen
    import serial_link_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic active,
    input  logic stay,
    output logic tick
);

    localparam int W = cnt_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] div_q, div_d;
    logic         tick_q, tick_d;

    // tick_d looks one cycle ahead so the strobe itself can come straight from a flop.
    always_comb begin
        div_d = '0;
        if (!start && active && !tick_q) begin
            div_d = div_q + W'(1);
        end
        tick_d = stay && (div_d == LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-in, serial-out word transmitter driving sr_out MSB-first with a per-bit shift strobe.
module serial_word_tx
    import serial_link_pkg::*;
#(
    parameter int N   = 8,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         data_valid,
    output logic         data_ready,
    output logic         sr_out,
    output logic         control,
    output logic         busy,
    output logic         done
);

    localparam int BW = cnt_width(N);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic           sr_out_q, sr_out_d;
    logic           done_q, done_d;
    logic           tick, accept, last_bit, active, stay;

    assign last_bit   = tick && (bit_q == BIT_LAST);
    assign data_ready = (state_q == IDLE) || last_bit;
    assign accept     = data_valid && data_ready;
    assign active     = (state_q == SHIFT);
    assign stay       = (state_d == SHIFT);

    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .start  (accept),
        .active (active),
        .stay   (stay),
        .tick   (tick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bit_d    = bit_q;
        sr_out_d = sr_out_q;
        done_d   = last_bit;
        if (accept) begin
            state_d  = SHIFT;
            shreg_d  = data_in;
            bit_d    = '0;
            sr_out_d = data_in[N-1];
        end else if (last_bit) begin
            state_d  = IDLE;
            bit_d    = '0;
            sr_out_d = 1'b0;
        end else if (tick) begin
            // sr_out_d takes the bit that becomes MSB after this shift.
            shreg_d  = shreg_q << 1;
            bit_d    = bit_q + BW'(1);
            sr_out_d = shreg_q[N-2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bit_q    <= '0;
            sr_out_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bit_q    <= bit_d;
            sr_out_q <= sr_out_d;
            done_q   <= done_d;
        end
    end

    assign busy    = active;
    assign control = tick;
    assign sr_out  = sr_out_q;
    assign done    = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench: instance 0 runs DIV=1, instance 1 runs DIV=3, each looped into a receiver shift register.
module tb_serial_word_tx;

    typedef struct packed {
        logic b;
        int   first;
        int   last;
    } bit_exp_t;

    typedef struct packed {
        logic [7:0] w;
        int         at;
    } word_exp_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid [2];
    logic [7:0] din   [2];
    logic       rdy   [2];
    logic       so    [2];
    logic       ctl   [2];
    logic       bsy   [2];
    logic       dn    [2];
    logic [7:0] rx    [2];

    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    bit_exp_t   bq [2][$];
    word_exp_t  wq [2][$];
    chk_t       chk_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        serial_word_tx #(.N(8), .DIV((g == 0) ? 1 : 3)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .data_in    (din[g]),
            .data_valid (valid[g]),
            .data_ready (rdy[g]),
            .sr_out     (so[g]),
            .control    (ctl[g]),
            .busy       (bsy[g]),
            .done       (dn[g])
        );
    end

    // Downstream serial-in receivers.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rx[0] <= '0;
            rx[1] <= '0;
        end else begin
            for (int g = 0; g < 2; g++)
                if (ctl[g]) rx[g] <= {rx[g][6:0], so[g]};
        end
    end

    task automatic cmp(input string name, input int g, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: actual %0d, required %0d", name, g, cyc, act, exp);
        end
    endtask

    // Monitor: drains direct checks and compares DUT outputs against the expectation queues.
    always @(negedge clk) begin
        chk_t      c;
        bit_exp_t  be;
        word_exp_t we;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(c.name, -1, c.act, c.exp);
        end
        if (!reset) begin
            for (int g = 0; g < 2; g++) begin
                if (bq[g].size() > 0 && cyc >= bq[g][0].first)
                    cmp("sr_out", g, int'(so[g]), int'(bq[g][0].b));
                if (ctl[g]) begin
                    if (bq[g].size() == 0) begin
                        cmp("control_unexpected", g, 1, 0);
                    end else begin
                        be = bq[g].pop_front();
                        cmp("control_cycle", g, cyc, be.last);
                    end
                end
                if (dn[g]) begin
                    if (wq[g].size() == 0) begin
                        cmp("done_unexpected", g, 1, 0);
                    end else begin
                        we = wq[g].pop_front();
                        cmp("done_cycle", g, cyc, we.at);
                        cmp("rx_word", g, int'(rx[g]), int'(we.w));
                    end
                end
            end
        end
    end

    task automatic expect_eq(input string name, input int act, input int exp);
        chk_q.push_back('{name, act, exp});
    endtask

    task automatic expect_idle(input int g, input string tag);
        expect_eq({tag, "_ready"},   int'(rdy[g]), 1);
        expect_eq({tag, "_busy"},    int'(bsy[g]), 0);
        expect_eq({tag, "_sr_out"},  int'(so[g]),  0);
        expect_eq({tag, "_control"}, int'(ctl[g]), 0);
        expect_eq({tag, "_done"},    int'(dn[g]),  0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int g, input logic [7:0] w, input bit keep, output int c0);
        int d;
        d = (g == 0) ? 1 : 3;
        valid[g] = 1'b1;
        din[g]   = w;
        c0 = -1;
        for (int k = 0; k < 200; k++) begin
            if (rdy[g]) begin
                c0 = cyc;
                break;
            end
            @(negedge clk);
        end
        if (c0 < 0) begin
            expect_eq("ready_timeout", 0, 1);
            valid[g] = 1'b0;
            return;
        end
        for (int i = 0; i < 8; i++)
            bq[g].push_back('{b: w[7-i], first: c0 + 1 + i * d, last: c0 + (i + 1) * d});
        wq[g].push_back('{w: w, at: c0 + 8 * d + 1});
        @(negedge clk);
        if (!keep) valid[g] = 1'b0;
    endtask

    task automatic drain(input int g);
        for (int k = 0; k < 100; k++) begin
            if (bq[g].size() == 0 && wq[g].size() == 0) break;
            @(negedge clk);
        end
        expect_eq("pending_expectations", bq[g].size() + wq[g].size(), 0);
        @(negedge clk);
        #1;
        expect_idle(g, "idle_after_frame");
    endtask

    initial begin
        int c0, c1;
        reset    = 1'b1;
        valid[0] = 1'b0;
        valid[1] = 1'b0;
        din[0]   = '0;
        din[1]   = '0;
        repeat (3) @(negedge clk);
        expect_idle(0, "reset");
        expect_idle(1, "reset");
        reset = 1'b0;
        @(negedge clk);

        // Single word, DIV=1.
        send(0, 8'hA5, 1'b0, c0);
        drain(0);

        // Divided rate, DIV=3.
        @(negedge clk);
        send(1, 8'h81, 1'b0, c0);
        drain(1);

        // Back-to-back with valid held high.
        @(negedge clk);
        send(0, 8'h12, 1'b1, c0);
        send(0, 8'h34, 1'b0, c1);
        expect_eq("b2b_accept_offset", c1 - c0, 8);
        drain(0);

        // Backpressure: valid pulsed mid-frame with changing data.
        @(negedge clk);
        send(0, 8'h5A, 1'b0, c0);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            valid[0] = 1'b1;
            din[0]   = (k % 2 == 0) ? 8'hFF : 8'h00;
            #1;
            expect_eq("bp_ready", int'(rdy[0]), 0);
            expect_eq("bp_busy",  int'(bsy[0]), 1);
        end
        @(negedge clk);
        valid[0] = 1'b0;
        drain(0);

        // Reset mid-frame, then a clean word.
        @(negedge clk);
        send(0, 8'hFF, 1'b0, c0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        expect_idle(0, "midframe_reset");
        bq[0].delete();
        wq[0].delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        expect_eq("ready_after_reset", int'(rdy[0]), 1);
        @(negedge clk);
        send(0, 8'h3C, 1'b0, c0);
        drain(0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
